// File: rtl/unscrambler2_pkg.sv
// rtl/unscrambler2_pkg.sv - shared widths and FSM encoding for the swap unscrambler
package unscrambler2_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LD_I = 3'd1,
      WR_I = 3'd2,
      WR_J = 3'd3,
      FIN  = 3'd4
   } state_t;

endpackage

// File: rtl/unscrambler2_log.sv
// rtl/unscrambler2_log.sv - LIFO of swap partner indices, one entry per forward swap step
module unscrambler2_log
   import unscrambler2_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 2**ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              wr,
   input  logic [ADDR_W-1:0] wr_j,
   input  logic              pop,
   input  logic [ADDR_W-1:0] rd_idx,
   output logic [ADDR_W-1:0] rd_j,
   output logic [ADDR_W:0]   count,
   output logic              ovf
);

   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic              full;
   logic              push;

   assign full = (count == FULL);
   assign push = wr && !clr && !full;

   // Entry contents need no reset; count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[count[ADDR_W-1:0]] <= wr_j;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         ovf   <= 1'b0;
      end else if (clr) begin
         count <= '0;
         ovf   <= 1'b0;
      end else if (wr) begin
         if (full) begin
            ovf <= 1'b1;
         end else begin
            count <= count + (ADDR_W+1)'(1);
         end
      end else if (pop && (count != '0)) begin
         count <= count - (ADDR_W+1)'(1);
      end
   end

   assign rd_j = mem[rd_idx];

endmodule

// File: rtl/unscrambler2.sv
// rtl/unscrambler2.sv - replays logged swaps in reverse against the shared regfile
module unscrambler2
   import unscrambler2_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 2**ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              log_clr,
   input  logic              log_wr,
   input  logic [ADDR_W-1:0] log_j,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count,
   output logic              ovf,
   output logic [ADDR_W-1:0] rf_r_addr,
   input  logic [DATA_W-1:0] rf_dout,
   output logic [ADDR_W-1:0] rf_w_addr,
   output logic [DATA_W-1:0] rf_din,
   output logic              rf_wr_en
);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] k;
   logic [ADDR_W-1:0] jr;
   logic [ADDR_W-1:0] log_rd_j;
   logic [DATA_W-1:0] temp;
   logic              idle;
   logic              count_zero;

   assign idle       = (state == IDLE);
   assign count_zero = (count == '0);

   // Log edits are only legal while idle; pops track the second write of each swap.
   unscrambler2_log #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_log (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (log_clr && idle),
      .wr     (log_wr && idle),
      .wr_j   (log_j),
      .pop    (state == WR_J),
      .rd_idx (k),
      .rd_j   (log_rd_j),
      .count  (count),
      .ovf    (ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = count_zero ? FIN : LD_I;
            end
         end
         LD_I:    state_nxt = WR_I;
         WR_I:    state_nxt = WR_J;
         WR_J:    state_nxt = (k == '0) ? FIN : LD_I;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // k walks the log from newest to oldest; jr and temp hold one swap in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k    <= '0;
         jr   <= '0;
         temp <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !count_zero) begin
                  k <= ADDR_W'(count - (ADDR_W+1)'(1));
               end
            end
            LD_I: begin
               temp <= rf_dout;
               jr   <= log_rd_j;
            end
            WR_J: begin
               if (k != '0) begin
                  k <= k - ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      rf_r_addr = '0;
      rf_w_addr = '0;
      rf_din    = '0;
      rf_wr_en  = 1'b0;
      case (state)
         LD_I: begin
            busy      = 1'b1;
            rf_r_addr = k;
         end
         WR_I: begin
            busy      = 1'b1;
            rf_r_addr = jr;
            rf_w_addr = k;
            rf_din    = rf_dout;
            rf_wr_en  = 1'b1;
         end
         WR_J: begin
            busy      = 1'b1;
            rf_w_addr = jr;
            rf_din    = temp;
            rf_wr_en  = 1'b1;
         end
         FIN: begin
            done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_unscrambler2.sv
// tb/tb_unscrambler2.sv - directed bench: round-trips, empty/self-swap, overflow, isolation, async reset
module tb_unscrambler2;

   localparam int AW = 5;
   localparam int DW = 8;
   localparam int D  = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          log_clr = 1'b0;
   logic          log_wr = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] log_j = '0;
   logic          busy, done, ovf, rf_wr_en;
   logic [AW:0]   count;
   logic [AW-1:0] rf_r_addr, rf_w_addr;
   logic [DW-1:0] rf_dout, rf_din;

   logic [DW-1:0] rf [D];
   logic [AW-1:0] jl [D];
   int n_cmp = 0;
   int n_bad = 0;
   int busy_c, done_c, wr_c, done_at;

   unscrambler2 #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .log_clr(log_clr), .log_wr(log_wr), .log_j(log_j),
      .start(start), .busy(busy), .done(done), .count(count), .ovf(ovf),
      .rf_r_addr(rf_r_addr), .rf_dout(rf_dout), .rf_w_addr(rf_w_addr),
      .rf_din(rf_din), .rf_wr_en(rf_wr_en)
   );

   always #5 clk = ~clk;

   // Regfile the DUT masters: combinational read, write at the clock edge.
   assign rf_dout = rf[rf_r_addr];
   always @(posedge clk) if (rf_wr_en) rf[rf_w_addr] = rf_din;

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] j);
      log_j = j; log_wr = 1'b1; cyc; log_wr = 1'b0;
   endtask

   task automatic clr_log;
      log_clr = 1'b1; cyc; log_clr = 1'b0;
   endtask

   task automatic fwd(input int n);
      logic [DW-1:0] t;
      for (int i = 0; i < n; i++) begin
         t = rf[i]; rf[i] = rf[jl[i]]; rf[jl[i]] = t;
      end
   endtask

   task automatic run_measure;
      busy_c = 0; done_c = 0; wr_c = 0; done_at = -1;
      start = 1'b1; cyc; start = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (busy) busy_c++;
         if (rf_wr_en) wr_c++;
         if (done) begin done_c++; if (done_at < 0) done_at = c; end
         cyc;
         if (done_at >= 0) begin
            if (done) done_c++;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; cyc; cyc;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
      n_cmp++; if (rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en got %b want 0", rf_wr_en); end
      n_cmp++; if (count !== 6'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", count); end
      n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %b want 0", ovf); end
      n_cmp++; if (rf_r_addr !== 5'd0 || rf_w_addr !== 5'd0) begin
         n_bad++; $display("FAIL rst_addr got r=%0d w=%0d want 0/0", rf_r_addr, rf_w_addr);
      end
      rst_n = 1'b1; cyc;
   endtask

   task automatic test_identity;
      logic [AW-1:0] js [8] = '{5'd3, 5'd0, 5'd7, 5'd2, 5'd2, 5'd5, 5'd1, 5'd6};
      clr_log;
      for (int a = 0; a < D; a++) rf[a] = 8'(a + 'h10);
      for (int i = 0; i < 8; i++) begin jl[i] = js[i]; push(js[i]); end
      n_cmp++; if (count !== 6'd8) begin n_bad++; $display("FAIL id_count_pre got %0d want 8", count); end
      fwd(8);
      run_measure;
      n_cmp++; if (busy_c != 24) begin n_bad++; $display("FAIL id_busy got %0d want 24", busy_c); end
      n_cmp++; if (done_at != 24) begin n_bad++; $display("FAIL id_done_at got %0d want 24", done_at); end
      n_cmp++; if (done_c != 1) begin n_bad++; $display("FAIL id_done_pulses got %0d want 1", done_c); end
      n_cmp++; if (wr_c != 16) begin n_bad++; $display("FAIL id_wr got %0d want 16", wr_c); end
      n_cmp++; if (count !== 6'd0) begin n_bad++; $display("FAIL id_count_post got %0d want 0", count); end
      for (int a = 0; a < D; a++) begin
         n_cmp++; if (rf[a] !== 8'(a + 'h10)) begin
            n_bad++; $display("FAIL id_rf[%0d] got %h want %h", a, rf[a], 8'(a + 'h10));
         end
      end
   endtask

   task automatic test_empty;
      clr_log;
      run_measure;
      n_cmp++; if (done_at != 0) begin n_bad++; $display("FAIL empty_done_at got %0d want 0", done_at); end
      n_cmp++; if (busy_c != 0) begin n_bad++; $display("FAIL empty_busy got %0d want 0", busy_c); end
      n_cmp++; if (wr_c != 0) begin n_bad++; $display("FAIL empty_wr got %0d want 0", wr_c); end
      n_cmp++; if (done_c != 1) begin n_bad++; $display("FAIL empty_done_pulses got %0d want 1", done_c); end
   endtask

   task automatic test_self_swap;
      clr_log;
      rf[0] = 8'hA5; rf[1] = 8'h3C;
      push(5'd0);
      run_measure;
      n_cmp++; if (rf[0] !== 8'hA5) begin n_bad++; $display("FAIL self_rf0 got %h want a5", rf[0]); end
      n_cmp++; if (rf[1] !== 8'h3C) begin n_bad++; $display("FAIL self_rf1 got %h want 3c", rf[1]); end
      n_cmp++; if (wr_c != 2) begin n_bad++; $display("FAIL self_wr got %0d want 2", wr_c); end
      n_cmp++; if (busy_c != 3) begin n_bad++; $display("FAIL self_busy got %0d want 3", busy_c); end
      n_cmp++; if (done_at != 3) begin n_bad++; $display("FAIL self_done_at got %0d want 3", done_at); end
   endtask

   task automatic test_overflow;
      clr_log;
      for (int a = 0; a < D; a++) rf[a] = 8'(~a);
      for (int i = 0; i < D; i++) begin jl[i] = 5'((i * 7 + 3) % 32); push(jl[i]); end
      push(5'd17);
      n_cmp++; if (count !== 6'd32) begin n_bad++; $display("FAIL ovf_count got %0d want 32", count); end
      n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", ovf); end
      fwd(D);
      run_measure;
      n_cmp++; if (busy_c != 96) begin n_bad++; $display("FAIL ovf_busy got %0d want 96", busy_c); end
      n_cmp++; if (done_at != 96) begin n_bad++; $display("FAIL ovf_done_at got %0d want 96", done_at); end
      n_cmp++; if (count !== 6'd0) begin n_bad++; $display("FAIL ovf_count_post got %0d want 0", count); end
      n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", ovf); end
      for (int a = 0; a < D; a++) begin
         n_cmp++; if (rf[a] !== 8'(~a)) begin
            n_bad++; $display("FAIL ovf_rf[%0d] got %h want %h", a, rf[a], 8'(~a));
         end
      end
      clr_log;
      n_cmp++; if (count !== 6'd0 || ovf !== 1'b0) begin
         n_bad++; $display("FAIL ovf_clr got count=%0d ovf=%b want 0/0", count, ovf);
      end
   endtask

   task automatic test_busy_isolation;
      logic [AW-1:0] js [5] = '{5'd4, 5'd1, 5'd4, 5'd0, 5'd2};
      clr_log;
      for (int a = 0; a < D; a++) rf[a] = 8'(a * 3 + 7);
      for (int i = 0; i < 5; i++) begin jl[i] = js[i]; push(js[i]); end
      fwd(5);
      start = 1'b1; cyc; start = 1'b0;
      for (int c = 0; c < 15; c++) begin
         n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL iso_busy c=%0d got %b want 1", c, busy); end
         n_cmp++; if (count !== 6'(5 - c / 3)) begin
            n_bad++; $display("FAIL iso_count c=%0d got %0d want %0d", c, count, 5 - c / 3);
         end
         log_j = 5'd4;
         log_wr = (c < 14); log_clr = (c < 14); start = (c < 14);
         cyc;
      end
      log_wr = 1'b0; log_clr = 1'b0; start = 1'b0;
      n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin
         n_bad++; $display("FAIL iso_fin got done=%b busy=%b want 1/0", done, busy);
      end
      cyc;
      n_cmp++; if (done !== 1'b0 || count !== 6'd0) begin
         n_bad++; $display("FAIL iso_idle got done=%b count=%0d want 0/0", done, count);
      end
      for (int a = 0; a < D; a++) begin
         n_cmp++; if (rf[a] !== 8'(a * 3 + 7)) begin
            n_bad++; $display("FAIL iso_rf[%0d] got %h want %h", a, rf[a], 8'(a * 3 + 7));
         end
      end
   endtask

   task automatic test_reset_mid_run;
      clr_log;
      for (int a = 0; a < D; a++) rf[a] = 8'(a);
      for (int i = 0; i < 8; i++) push(5'(i + 2));
      start = 1'b1; cyc; start = 1'b0;
      repeat (7) cyc;
      n_cmp++; if (rf_wr_en !== 1'b1 || rf_w_addr !== 5'd5) begin
         n_bad++; $display("FAIL mid_pre got wr_en=%b w_addr=%0d want 1/5", rf_wr_en, rf_w_addr);
      end
      rst_n = 1'b0; #1;
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || rf_wr_en !== 1'b0) begin
         n_bad++; $display("FAIL mid_rst got busy=%b done=%b wr_en=%b want 0/0/0", busy, done, rf_wr_en);
      end
      n_cmp++; if (count !== 6'd0 || ovf !== 1'b0) begin
         n_bad++; $display("FAIL mid_rst_log got count=%0d ovf=%b want 0/0", count, ovf);
      end
      cyc; rst_n = 1'b1; cyc;
      run_measure;
      n_cmp++; if (done_at != 0 || done_c != 1) begin
         n_bad++; $display("FAIL mid_after got done_at=%0d pulses=%0d want 0/1", done_at, done_c);
      end
      n_cmp++; if (busy_c != 0 || wr_c != 0) begin
         n_bad++; $display("FAIL mid_after_idle got busy=%0d wr=%0d want 0/0", busy_c, wr_c);
      end
   endtask

   initial begin
      for (int a = 0; a < D; a++) begin rf[a] = '0; jl[a] = '0; end
      test_reset;
      test_identity;
      test_empty;
      test_self_swap;
      test_overflow;
      test_busy_isolation;
      test_reset_mid_run;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
